// File: rtl/router_pkg.sv
// Shared flit-layout constants and helpers for the tree router family.
// The flit format is {route[MAX_HOPS*NUM_PORTS-1:0], payload}. The source-route generator uses the same layout.
package router_pkg;

  function automatic int flit_w(input int num_ports, input int payload_w, input int max_hops);
    return max_hops * num_ports + payload_w;
  endfunction

  function automatic int cnt_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  // Index one past i, wrapping at n; used by the round-robin pointer.
  function automatic int wrap_inc(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flop-array FIFO with a combinational head. A push while full is ignored,
// even when a pop happens in the same cycle.
module flit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;
  logic                    do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/param_tree_router.sv
// Source-routed, credit-flow-controlled N-port router. It uses round-robin
// switch allocation and atomic multicast. Each hop consumes the low NUM_PORTS route bits.
module param_tree_router
  import router_pkg::*;
#(
  parameter int NUM_PORTS   = 5,
  parameter int PAYLOAD_W   = 32,
  parameter int MAX_HOPS    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int OUT_CREDITS = 4,
  localparam int FLIT_W     = flit_w(NUM_PORTS, PAYLOAD_W, MAX_HOPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_data_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_credit,
  output logic [NUM_PORTS-1:0]        out_data_valid,
  output logic [NUM_PORTS*FLIT_W-1:0] out_data,
  input  logic [NUM_PORTS-1:0]        out_credit,
  output logic [NUM_PORTS-1:0]        err_overflow,
  output logic [NUM_PORTS-1:0]        err_credit
);
  localparam int RW  = MAX_HOPS * NUM_PORTS;
  localparam int CW  = cnt_w(OUT_CREDITS);
  localparam int RRW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0][FLIT_W-1:0]    in_flit, head, shifted, out_d, out_d_nxt;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0][CW-1:0]        cnt;
  logic [NUM_PORTS-1:0]                full, empty, pop, grant, taken, has_cr;
  logic [RRW-1:0]                      rr, rr_nxt;

  assign in_flit  = in_data;
  assign out_data = out_d;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [RW-1:0] route;

    flit_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_data_valid[p]),
      .din   (in_flit[p]),
      .pop   (pop[p]),
      .head  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );

    assign route      = head[p][FLIT_W-1:PAYLOAD_W];
    assign mask[p]    = route[NUM_PORTS-1:0];
    assign shifted[p] = {route >> NUM_PORTS, head[p][PAYLOAD_W-1:0]};
    assign has_cr[p]  = (cnt[p] != '0);
  end

  // Scan from rr. A multicast head is granted only when every requested output is free and has credit.
  always_comb begin
    int  idx;
    logic found;
    grant  = '0;
    pop    = '0;
    taken  = '0;
    rr_nxt = rr;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!empty[idx]) begin
        if (mask[idx] == '0) begin
          pop[idx] = 1'b1;
        end else if (((mask[idx] & ~has_cr) == '0) && ((mask[idx] & taken) == '0)) begin
          grant[idx] = 1'b1;
          pop[idx]   = 1'b1;
          taken      = taken | mask[idx];
          if (!found) begin
            found  = 1'b1;
            rr_nxt = RRW'(wrap_inc(idx, NUM_PORTS));
          end
        end
      end
    end
  end

  always_comb begin
    out_d_nxt = '0;
    for (int q = 0; q < NUM_PORTS; q++)
      for (int i = 0; i < NUM_PORTS; i++)
        if (grant[i] && mask[i][q]) out_d_nxt[q] = shifted[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr             <= '0;
      out_data_valid <= '0;
      out_d          <= '0;
      in_credit      <= '0;
      err_overflow   <= '0;
      err_credit     <= '0;
      for (int q = 0; q < NUM_PORTS; q++) cnt[q] <= CW'(OUT_CREDITS);
    end else begin
      rr             <= rr_nxt;
      out_data_valid <= taken;
      out_d          <= out_d_nxt;
      in_credit      <= pop;
      err_overflow   <= err_overflow | (in_data_valid & full);
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (taken[q] && !out_credit[q]) begin
          cnt[q] <= cnt[q] - 1'b1;
        end else if (out_credit[q] && !taken[q]) begin
          // A credit returned while the counter is already full means the downstream miscounted.
          if (cnt[q] == CW'(OUT_CREDITS)) err_credit[q] <= 1'b1;
          else                            cnt[q] <= cnt[q] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_tree_router.sv
// Scoreboard bench for param_tree_router. A queue-level reference model predicts
// outputs and credit pulses, and a negedge monitor compares them to the DUT.
module tb_param_tree_router;
  localparam int NP = 5, PW = 32, MH = 4, FD = 4, OC = 4;
  localparam int RW = MH * NP, FW = RW + PW;

  logic            clk = 1'b0, rst = 1'b1;
  logic [NP-1:0]   in_data_valid = '0, in_credit, out_data_valid, err_overflow, err_credit;
  logic [NP*FW-1:0] in_data = '0, out_data;
  logic [NP-1:0]   out_credit, auto_cr = '0, man_cr = '0;

  assign out_credit = auto_cr | man_cr;

  param_tree_router #(.NUM_PORTS(NP), .PAYLOAD_W(PW), .MAX_HOPS(MH),
                      .FIFO_DEPTH(FD), .OUT_CREDITS(OC)) dut (
    .clk(clk), .rst(rst), .in_data_valid(in_data_valid), .in_data(in_data),
    .in_credit(in_credit), .out_data_valid(out_data_valid), .out_data(out_data),
    .out_credit(out_credit), .err_overflow(err_overflow), .err_credit(err_credit));

  always #5 clk = ~clk;

  typedef struct { int tag; logic [FW-1:0] d; } exp_t;

  exp_t          exp_out[NP][$];
  int            exp_cr[NP][$];
  logic [FW-1:0] mq[NP][$];
  int            cred[NP], owed[NP];
  int            rr = 0, cyc = 0, cr_prob = 0;
  logic [NP-1:0] exp_ovf = '0, exp_cerr = '0;
  int            checks = 0, errors = 0;

  function automatic logic [FW-1:0] hop(input logic [FW-1:0] f);
    logic [RW-1:0] r;
    r = f[FW-1:PW];
    r = r >> NP;
    return {r, f[PW-1:0]};
  endfunction

  // Reference model: queues per input, integer credits, spec-level allocation rules.
  always @(posedge clk) begin
    logic [NP-1:0] tk, pp, m;
    logic [FW-1:0] f;
    int sz[NP];
    int first, i;
    bit ok;
    cyc++;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete(); exp_out[p].delete(); exp_cr[p].delete();
        cred[p] = OC; owed[p] = 0;
      end
      rr = 0; exp_ovf = '0; exp_cerr = '0;
    end else begin
      tk = '0; pp = '0; first = -1;
      for (int p = 0; p < NP; p++) sz[p] = mq[p].size();
      for (int k = 0; k < NP; k++) begin
        i = (rr + k) % NP;
        if (sz[i] > 0) begin
          f = mq[i][0];
          m = f[PW +: NP];
          if (m == '0) pp[i] = 1'b1;
          else begin
            ok = 1;
            for (int q = 0; q < NP; q++) if (m[q] && (cred[q] == 0 || tk[q])) ok = 0;
            if (ok) begin
              pp[i] = 1'b1;
              tk = tk | m;
              if (first < 0) first = i;
              for (int q = 0; q < NP; q++) if (m[q]) exp_out[q].push_back('{cyc, hop(f)});
            end
          end
        end
      end
      for (int p = 0; p < NP; p++) if (pp[p]) begin
        void'(mq[p].pop_front());
        exp_cr[p].push_back(cyc);
      end
      for (int q = 0; q < NP; q++) begin
        if (tk[q]) owed[q]++;
        if (tk[q] && !out_credit[q]) cred[q]--;
        else if (out_credit[q] && !tk[q]) begin
          if (cred[q] == OC) exp_cerr[q] = 1'b1;
          else cred[q]++;
        end
      end
      if (first >= 0) rr = (first + 1) % NP;
      for (int p = 0; p < NP; p++) if (in_data_valid[p]) begin
        if (sz[p] >= FD) exp_ovf[p] = 1'b1;
        else mq[p].push_back(in_data[p*FW +: FW]);
      end
    end
  end

  // Downstream model: returns owed credits with probability cr_prob percent.
  always @(negedge clk) begin
    for (int q = 0; q < NP; q++) begin
      if (owed[q] > 0 && $urandom_range(99) < cr_prob) begin
        auto_cr[q] = 1'b1; owed[q]--;
      end else auto_cr[q] = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    for (int q = 0; q < NP; q++) begin
      if (out_data_valid[q]) begin
        checks++;
        if (exp_out[q].size() == 0) begin
          errors++; $display("FAIL out%0d unexpected flit %h at cyc %0d", q, out_data[q*FW +: FW], cyc);
        end else begin
          e = exp_out[q].pop_front();
          if (e.tag != cyc || e.d !== out_data[q*FW +: FW]) begin
            errors++;
            $display("FAIL out%0d got %h at cyc %0d, want %h at cyc %0d", q, out_data[q*FW +: FW], cyc, e.d, e.tag);
          end
        end
      end else if (exp_out[q].size() > 0 && exp_out[q][0].tag <= cyc) begin
        checks++; errors++;
        e = exp_out[q].pop_front();
        $display("FAIL out%0d missing flit %h due cyc %0d (now %0d)", q, e.d, e.tag, cyc);
      end
      if (in_credit[q]) begin
        checks++;
        if (exp_cr[q].size() == 0 || exp_cr[q][0] != cyc) begin
          errors++; $display("FAIL in_credit%0d unexpected pulse at cyc %0d", q, cyc);
        end
        if (exp_cr[q].size() > 0 && exp_cr[q][0] <= cyc) void'(exp_cr[q].pop_front());
      end else if (exp_cr[q].size() > 0 && exp_cr[q][0] <= cyc) begin
        checks++; errors++;
        $display("FAIL in_credit%0d missing pulse due cyc %0d (now %0d)", q, exp_cr[q][0], cyc);
        void'(exp_cr[q].pop_front());
      end
    end
    checks++;
    if (err_overflow !== exp_ovf || err_credit !== exp_cerr) begin
      errors++;
      $display("FAIL err flags got ovf=%b cerr=%b, want ovf=%b cerr=%b at cyc %0d",
               err_overflow, err_credit, exp_ovf, exp_cerr, cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      in_data_valid = '0;
    end
  endtask

  task automatic send(input int p, input logic [NP-1:0] m, input logic [PW-1:0] pl);
    logic [RW-1:0] r;
    r = RW'($urandom);
    r[NP-1:0] = m;
    in_data_valid[p] = 1'b1;
    in_data[p*FW +: FW] = {r, pl};
  endtask

  task automatic do_reset();
    rst = 1'b1; in_data_valid = '0; man_cr = '0;
    @(negedge clk);
    checks++;
    if (out_data_valid !== '0 || out_data !== '0 || in_credit !== '0 ||
        err_overflow !== '0 || err_credit !== '0) begin
      errors++;
      $display("FAIL reset state got v=%b cr=%b ovf=%b cerr=%b data_nz=%0d, want all 0",
               out_data_valid, in_credit, err_overflow, err_credit, out_data != '0);
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Unicast
    send(0, 5'b00100, 32'hA5A5A5A5); tick(); tick(4);

    // Multicast blocked by output 3 credit
    cr_prob = 0;
    for (int k = 0; k < OC; k++) begin send(0, 5'b01000, $urandom); tick(); end
    tick(2);
    send(4, 5'b11110, 32'h1234_5678); tick(); tick(5);
    man_cr = 5'b01000; tick(); man_cr = '0; tick(4);
    cr_prob = 100; tick(10);

    // Contention fairness on output 4
    for (int k = 0; k < 30; k++) begin
      send(0, 5'b10000, k); send(1, 5'b10000, k + 100); send(2, 5'b10000, k + 200); tick();
    end
    tick(20);

    // Back-pressure and overflow on port 3
    do_reset(); cr_prob = 0;
    for (int k = 0; k < OC; k++) begin send(0, 5'b00010, $urandom); tick(); end
    for (int k = 0; k <= FD; k++) begin send(3, 5'b00010, 32'hC0DE_0000 + k); tick(); end
    tick(6);
    cr_prob = 100; tick(15);

    // Credit edge cases: overflow credit, then send and credit in the same cycle
    do_reset(); cr_prob = 0;
    man_cr = 5'b00100; tick(); man_cr = '0; tick(2);
    send(1, 5'b00001, 32'hFACE); tick(); man_cr = 5'b00001; tick(); man_cr = '0;
    for (int k = 0; k < OC + 1; k++) begin send(1, 5'b00001, k); tick(); end
    tick(4);
    cr_prob = 100; tick(10);

    // Empty mask, then reset with flits buffered
    send(2, 5'b00000, 32'hDEAD); tick(); tick(3);
    cr_prob = 0;
    for (int k = 0; k < OC; k++) begin send(0, 5'b00001, k); tick(); end
    for (int k = 0; k < 3; k++) begin send(1, 5'b00001, k); tick(); end
    tick(2);
    do_reset();
    send(2, 5'b00001, 32'hBEEF); tick(); tick(4);

    // Randomised traffic
    do_reset(); cr_prob = 60;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(99) < 35)
          send(p, ($urandom_range(7) == 0) ? 5'b0 : 5'($urandom), $urandom);
      tick();
    end
    cr_prob = 100; tick(60);

    for (int q = 0; q < NP; q++) begin
      checks++;
      if (exp_out[q].size() != 0 || exp_cr[q].size() != 0) begin
        errors++;
        $display("FAIL drain port%0d left %0d flits / %0d credits pending, want 0",
                 q, exp_out[q].size(), exp_cr[q].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
